// File: rtl/tdm_scan_seq.sv
// tdm_scan_seq: latches one byte per handshake and sweeps the 3-bit channel
// select {sel_a,sel_b,sel_c} over all 8 channels, holding each for DWELL cycles.
module tdm_scan_seq #(
  parameter int DWELL = 4,
  parameter int DIR   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       abort,
  output logic [7:0] data_out,
  output logic       sel_a,
  output logic       sel_b,
  output logic       sel_c,
  output logic       scan_active,
  output logic       ch_strobe,
  output logic       frame_done
);

  localparam int            CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [2:0]    FIRST   = (DIR == 0) ? 3'd0 : 3'd7;
  localparam logic [2:0]    LAST    = (DIR == 0) ? 3'd7 : 3'd0;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic [2:0]      sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= FIRST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; abort overrides every state
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    accept  = in_valid && in_ready;
    if (abort) begin
      state_d = IDLE;
      data_d  = '0;
      sel_d   = FIRST;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_d = SCAN;
            data_d  = in_data;
            sel_d   = FIRST;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        SCAN: begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end else if (sel_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            sel_d = (DIR == 0) ? sel_q + 3'd1 : sel_q - 3'd1;
            cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    in_ready    = ((state_q == IDLE) || (state_q == DONE)) && !abort;
    data_out    = data_q;
    sel_a       = sel_q[2];
    sel_b       = sel_q[1];
    sel_c       = sel_q[0];
    scan_active = (state_q == SCAN);
    ch_strobe   = (state_q == SCAN) && (cnt_q == '0);
    frame_done  = (state_q == DONE);
  end

endmodule
